patch_control_unit: RTL and testbench

Runtime patch controller that closes the control loop of a patchable design module. It consumes the module's `control_port_in` (unpatched internal values) and `observe_port` (monitored nets), and drives `control_port_out` back into the module. While a programmed trigger condition is active, it applies per-bit override modes; otherwise it passes values straight through. Configuration arrives over a simple write-only register interface from the SoC patch fabric.

---
 rtl/patch_control_unit.sv | 169 ++++++++++++++++
 tb/tb_patch_control_unit.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/patch_control_unit.sv
// Runtime patch controller: watches observe nets for a programmed trigger and
// overrides control bits with per-bit modes while the patch window is open.
module patch_control_unit #(
  parameter int unsigned CTRL_W = 4,
  parameter int unsigned OBS_W  = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cfg_we,
  input  logic [2:0]        cfg_addr,
  input  logic [7:0]        cfg_wdata,
  input  logic [CTRL_W-1:0] control_port_in,
  input  logic [OBS_W-1:0]  observe_port,
  output logic [CTRL_W-1:0] control_port_out,
  output logic              patch_active,
  output logic [7:0]        trig_count
);

  localparam int unsigned MODE_W = 2 * CTRL_W;
  localparam int unsigned CNT_W  = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    PATCH = 2'd2
  } state_t;

  logic              r_arm;
  logic              r_sticky;
  logic [OBS_W-1:0]  r_mask;
  logic [OBS_W-1:0]  r_value;
  logic [MODE_W-1:0] r_mode;
  logic [CNT_W-1:0]  r_match_len;
  logic [CNT_W-1:0]  r_patch_len;

  state_t            r_state;
  logic [CNT_W-1:0]  r_match_cnt;
  logic [CNT_W-1:0]  r_patch_cnt;
  logic [CNT_W-1:0]  r_trig_count;

  state_t            w_state_nxt;
  logic [CNT_W-1:0]  w_match_nxt;
  logic [CNT_W-1:0]  w_patch_nxt;
  logic              w_fire;
  logic              w_ctrl_wr;
  logic              w_disarm;
  logic              w_clr;
  logic              w_hit;
  logic [CNT_W-1:0]  w_match_len;
  logic [CNT_W-1:0]  w_patch_len;

  assign w_ctrl_wr   = cfg_we && (cfg_addr == 3'd0);
  // A disarm write wins over a trigger landing on the same edge.
  assign w_disarm    = !r_arm || (w_ctrl_wr && !cfg_wdata[0]);
  assign w_clr       = w_ctrl_wr && cfg_wdata[2];
  assign w_hit       = ((observe_port ^ r_value) & r_mask) == '0;
  assign w_match_len = (r_match_len == '0) ? CNT_W'(1) : r_match_len;
  assign w_patch_len = (r_patch_len == '0) ? CNT_W'(1) : r_patch_len;

  // Configuration register file; reserved addresses fall through.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_arm       <= 1'b0;
      r_sticky    <= 1'b0;
      r_mask      <= '0;
      r_value     <= '0;
      r_mode      <= '0;
      r_match_len <= '0;
      r_patch_len <= '0;
    end else if (cfg_we) begin
      case (cfg_addr)
        3'd0: begin
          r_arm    <= cfg_wdata[0];
          r_sticky <= cfg_wdata[1];
        end
        3'd1:    r_mask      <= cfg_wdata[OBS_W-1:0];
        3'd2:    r_value     <= cfg_wdata[OBS_W-1:0];
        3'd3:    r_mode      <= cfg_wdata[MODE_W-1:0];
        3'd4:    r_match_len <= cfg_wdata;
        3'd5:    r_patch_len <= cfg_wdata;
        default: ;
      endcase
    end
  end

  // State and counter registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= IDLE;
      r_match_cnt  <= '0;
      r_patch_cnt  <= '0;
      r_trig_count <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_match_cnt <= w_match_nxt;
      r_patch_cnt <= w_patch_nxt;
      if (w_clr)
        r_trig_count <= '0;
      else if (w_fire && (r_trig_count != 8'hFF))
        r_trig_count <= r_trig_count + CNT_W'(1);
    end
  end

  // Next-state logic; the IDLE->ARMED edge already samples the first hit.
  always_comb begin
    w_state_nxt = r_state;
    w_match_nxt = r_match_cnt;
    w_patch_nxt = r_patch_cnt;
    w_fire      = 1'b0;
    if (w_disarm) begin
      w_state_nxt = IDLE;
      w_match_nxt = '0;
      w_patch_nxt = '0;
    end else begin
      case (r_state)
        IDLE: begin
          w_state_nxt = ARMED;
          w_match_nxt = w_hit ? CNT_W'(1) : CNT_W'(0);
        end
        ARMED: begin
          if (!w_hit) begin
            w_match_nxt = '0;
          end else if (({1'b0, r_match_cnt} + 9'd1) >= {1'b0, w_match_len}) begin
            w_state_nxt = PATCH;
            w_match_nxt = '0;
            w_patch_nxt = w_patch_len;
            w_fire      = 1'b1;
          end else begin
            w_match_nxt = r_match_cnt + CNT_W'(1);
          end
        end
        PATCH: begin
          if (!r_sticky) begin
            if (r_patch_cnt <= CNT_W'(1)) begin
              w_state_nxt = ARMED;
              w_patch_nxt = '0;
            end else begin
              w_patch_nxt = r_patch_cnt - CNT_W'(1);
            end
          end
        end
        default: begin
          w_state_nxt = IDLE;
          w_match_nxt = '0;
          w_patch_nxt = '0;
        end
      endcase
    end
  end

  // Zero-latency override path.
  always_comb begin
    control_port_out = control_port_in;
    if (r_state == PATCH) begin
      for (int i = 0; i < CTRL_W; i++) begin
        case (r_mode[2*i +: 2])
          2'b01:   control_port_out[i] = 1'b0;
          2'b10:   control_port_out[i] = 1'b1;
          2'b11:   control_port_out[i] = ~control_port_in[i];
          default: control_port_out[i] = control_port_in[i];
        endcase
      end
    end
  end

  assign patch_active = (r_state == PATCH);
  assign trig_count   = r_trig_count;

endmodule

// File: tb/tb_patch_control_unit.sv
// Self-checking bench for patch_control_unit: directed scenarios plus random
// traffic, compared every cycle against a behavioural model.
module tb_patch_control_unit;

  logic       clk = 1'b0;
  logic       rst;
  logic       cfg_we;
  logic [2:0] cfg_addr;
  logic [7:0] cfg_wdata;
  logic [3:0] control_port_in;
  logic [1:0] observe_port;
  logic [3:0] control_port_out;
  logic       patch_active;
  logic [7:0] trig_count;

  int n_checks = 0;
  int n_err    = 0;
  bit chk_en   = 1'b0;

  // Model state: armed flag, current hit streak, remaining patch cycles.
  bit         m_on;
  int         m_streak;
  int         m_left;
  int         m_count;
  bit         m_arm, m_sticky;
  logic [1:0] m_mask, m_value;
  logic [7:0] m_mode;
  int         m_ml, m_pl;

  always #5 clk = ~clk;

  patch_control_unit #(.CTRL_W(4), .OBS_W(2)) dut (
    .clk              (clk),
    .rst              (rst),
    .cfg_we           (cfg_we),
    .cfg_addr         (cfg_addr),
    .cfg_wdata        (cfg_wdata),
    .control_port_in  (control_port_in),
    .observe_port     (observe_port),
    .control_port_out (control_port_out),
    .patch_active     (patch_active),
    .trig_count       (trig_count)
  );

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  function automatic logic [3:0] exp_out();
    logic [3:0] r;
    int md;
    r = control_port_in;
    if (m_left > 0) begin
      for (int i = 0; i < 4; i++) begin
        md = (int'(m_mode) >> (2 * i)) % 4;
        if (md == 1)      r[i] = 1'b0;
        else if (md == 2) r[i] = 1'b1;
        else if (md == 3) r[i] = ~control_port_in[i];
      end
    end
    return r;
  endfunction

  // One clock edge: advance the model from the inputs that were applied.
  task automatic step();
    bit wr0, disarm, hit, fire;
    @(posedge clk);
    if (rst) begin
      m_on = 0; m_streak = 0; m_left = 0; m_count = 0;
      m_arm = 0; m_sticky = 0; m_mask = 0; m_value = 0; m_mode = 0;
      m_ml = 0; m_pl = 0;
    end else begin
      wr0    = cfg_we && (cfg_addr == 3'd0);
      disarm = !m_arm || (wr0 && !cfg_wdata[0]);
      hit    = ((observe_port ^ m_value) & m_mask) == 2'b00;
      fire   = 0;
      if (disarm) begin
        m_on = 0; m_streak = 0; m_left = 0;
      end else if (!m_on) begin
        m_on = 1;
        m_streak = hit ? 1 : 0;
      end else if (m_left > 0) begin
        if (!m_sticky) m_left = m_left - 1;
      end else if (hit) begin
        if (m_streak + 1 >= ((m_ml == 0) ? 1 : m_ml)) begin
          m_left   = (m_pl == 0) ? 1 : m_pl;
          m_streak = 0;
          fire     = 1;
        end else begin
          m_streak = m_streak + 1;
        end
      end else begin
        m_streak = 0;
      end
      if (wr0 && cfg_wdata[2]) m_count = 0;
      else if (fire && m_count < 255) m_count = m_count + 1;
      if (cfg_we) begin
        case (cfg_addr)
          3'd0: begin m_arm = cfg_wdata[0]; m_sticky = cfg_wdata[1]; end
          3'd1: m_mask  = cfg_wdata[1:0];
          3'd2: m_value = cfg_wdata[1:0];
          3'd3: m_mode  = cfg_wdata;
          3'd4: m_ml    = int'(cfg_wdata);
          3'd5: m_pl    = int'(cfg_wdata);
          default: ;
        endcase
      end
    end
    #1;
  endtask

  task automatic wr(input logic [2:0] a, input logic [7:0] d);
    cfg_we = 1'b1; cfg_addr = a; cfg_wdata = d;
    step();
    cfg_we = 1'b0;
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (chk_en) begin
      check("control_port_out", int'(control_port_out), int'(exp_out()));
      check("patch_active", int'(patch_active), (m_left > 0) ? 1 : 0);
      check("trig_count", int'(trig_count), m_count);
    end
  end

  initial begin
    logic [7:0] d;
    rst = 1'b1; cfg_we = 1'b0; cfg_addr = 3'd0; cfg_wdata = 8'd0;
    control_port_in = 4'b1010; observe_port = 2'b00;
    step();
    chk_en = 1'b1;
    check("reset_out", int'(control_port_out), 10);
    check("reset_active", int'(patch_active), 0);
    check("reset_count", int'(trig_count), 0);
    rst = 1'b0;

    // Basic trigger: 3 hits, 2-cycle patch.
    control_port_in = 4'b1111;
    wr(3'd3, 8'b11_10_01_00);
    wr(3'd1, 8'h03);
    wr(3'd2, 8'h01);
    wr(3'd4, 8'd3);
    wr(3'd5, 8'd2);
    wr(3'd0, 8'h01);
    step();
    check("armed_no_patch", int'(patch_active), 0);
    observe_port = 2'b01;
    steps(3);
    observe_port = 2'b00;
    check("trig_active", int'(patch_active), 1);
    check("trig_out", int'(control_port_out), 5);
    check("trig_count1", int'(trig_count), 1);
    step();
    check("patch_cycle2", int'(patch_active), 1);
    step();
    check("patch_end", int'(patch_active), 0);
    check("patch_end_out", int'(control_port_out), 15);

    // Broken match restarts the streak.
    foreach (d[i]) if (i < 5) begin
      observe_port = (i == 2) ? 2'b00 : 2'b01;
      step();
    end
    check("broken_no_patch", int'(patch_active), 0);
    observe_port = 2'b01;
    step();
    observe_port = 2'b00;
    check("rehit_patch", int'(patch_active), 1);
    check("trig_count2", int'(trig_count), 2);
    steps(2);

    // Sticky with MATCH_LEN=0 and an always-hit mask.
    wr(3'd0, 8'h00);
    wr(3'd4, 8'd0);
    wr(3'd1, 8'h00);
    wr(3'd0, 8'h03);
    step();
    check("sticky_first", int'(patch_active), 0);
    step();
    check("sticky_patch", int'(patch_active), 1);
    steps(100);
    check("sticky_held", int'(patch_active), 1);
    wr(3'd0, 8'h00);
    check("disarm_idle", int'(patch_active), 0);
    check("disarm_out", int'(control_port_out), 15);

    // Saturation and clear.
    wr(3'd5, 8'd1);
    wr(3'd0, 8'h01);
    steps(600);
    check("saturate", int'(trig_count), 255);
    wr(3'd0, 8'h05);
    check("clr_cnt", int'(trig_count), 0);

    // Disarm coinciding with the final hit.
    wr(3'd0, 8'h00);
    wr(3'd4, 8'd2);
    wr(3'd1, 8'h03);
    wr(3'd0, 8'h01);
    step();
    observe_port = 2'b01;
    step();
    wr(3'd0, 8'h00);
    observe_port = 2'b00;
    check("disarm_wins", int'(patch_active), 0);

    // Reset mid-patch, with a concurrent write that must be dropped.
    wr(3'd1, 8'h00);
    wr(3'd0, 8'h03);
    steps(3);
    check("pre_rst_patch", int'(patch_active), 1);
    rst = 1'b1; cfg_we = 1'b1; cfg_addr = 3'd0; cfg_wdata = 8'h03;
    step();
    rst = 1'b0; cfg_we = 1'b0;
    check("rst_out", int'(control_port_out), 15);
    check("rst_active", int'(patch_active), 0);
    steps(3);
    check("rst_disarmed", int'(patch_active), 0);

    // Random traffic.
    for (int n = 0; n < 4000; n++) begin
      rst    = ($urandom_range(0, 299) == 0);
      cfg_we = ($urandom_range(0, 5) == 0);
      cfg_addr = 3'($urandom_range(0, 7));
      d = 8'($urandom);
      if (cfg_addr == 3'd0 && $urandom_range(0, 7) != 0) d[0] = 1'b1;
      if (cfg_addr == 3'd4 || cfg_addr == 3'd5) d = 8'($urandom_range(0, 4));
      cfg_wdata = d;
      observe_port = 2'($urandom);
      control_port_in = 4'($urandom);
      step();
    end
    rst = 1'b0; cfg_we = 1'b0;
    step();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
